// File: rtl/div_unit_pkg.sv
// Shared encodings for the EX-stage iterative divider: FSM states,
// result-ready and stall-request levels.
package div_unit_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic Stop              = 1'b1;
  localparam logic NoStop            = 1'b0;

endpackage

// File: rtl/div_unit_step.sv
// One restoring-division step: shift {rem, quo} left by one, then
// trial-subtract the divisor at WIDTH+1 bits.
module div_unit_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] trial;
  logic [WIDTH:0] diff;

  assign trial = {rem_i, quo_i[WIDTH-1]};
  assign diff  = trial - {1'b0, dvs_i};

  // A borrow (diff MSB set) means the divisor did not fit: restore.
  assign rem_o = diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quo_o = {quo_i[WIDTH-2:0], ~diff[WIDTH]};

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU; holds the EX stall
// request while a division is in flight and pulses ready_o with {HI, LO}.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stallreq_for_ex
);

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

  div_state_e         state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   rem_q, dvd_q, dvs_q;
  logic               neg_quo_q, neg_rem_q;
  logic [2*WIDTH-1:0] result_q;
  logic               ready_q;

  logic               op1_neg, op2_neg;
  logic [WIDTH-1:0]   op1_abs, op2_abs;
  logic [WIDTH-1:0]   rem_d, quo_d, rem_fix, quo_fix;

  // |0x80..0| wraps to itself, which the unsigned core handles correctly.
  assign op1_neg = signed_div_i & opdata1_i[WIDTH-1];
  assign op2_neg = signed_div_i & opdata2_i[WIDTH-1];
  assign op1_abs = op1_neg ? (~opdata1_i + WIDTH'(1)) : opdata1_i;
  assign op2_abs = op2_neg ? (~opdata2_i + WIDTH'(1)) : opdata2_i;

  div_unit_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .quo_i (dvd_q),
    .dvs_i (dvs_q),
    .rem_o (rem_d),
    .quo_o (quo_d)
  );

  assign quo_fix = neg_quo_q ? (~quo_d + WIDTH'(1)) : quo_d;
  assign rem_fix = neg_rem_q ? (~rem_d + WIDTH'(1)) : rem_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= DivFree;
      cnt_q     <= '0;
      rem_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      ready_q   <= DivResultNotReady;
    end else begin
      ready_q <= DivResultNotReady;
      case (state_q)
        DivFree: begin
          if (start_i && !annul_i) begin
            if (opdata2_i == '0) begin
              state_q <= DivByZero;
            end else begin
              dvd_q     <= op1_abs;
              dvs_q     <= op2_abs;
              rem_q     <= '0;
              neg_quo_q <= op1_neg ^ op2_neg;
              neg_rem_q <= op1_neg;
              cnt_q     <= '0;
              state_q   <= DivOn;
            end
          end
        end
        DivByZero: begin
          if (annul_i) begin
            state_q <= DivFree;
          end else begin
            result_q <= '0;
            ready_q  <= DivResultReady;
            state_q  <= DivEnd;
          end
        end
        DivOn: begin
          if (annul_i) begin
            state_q <= DivFree;
          end else begin
            rem_q <= rem_d;
            dvd_q <= quo_d;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == LastCnt) begin
              result_q <= {rem_fix, quo_fix};
              ready_q  <= DivResultReady;
              state_q  <= DivEnd;
            end
          end
        end
        DivEnd:  state_q <= DivFree;
        default: state_q <= DivFree;
      endcase
    end
  end

  assign result_o        = result_q;
  assign ready_o         = ready_q;
  assign stallreq_for_ex = (start_i && (state_q != DivEnd)) ? Stop : NoStop;

endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit: latency, stall window, signed fix-up,
// divide-by-zero, annul, async reset and back-to-back operation.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, sgn, annul;
  logic [31:0] op1, op2;
  logic [63:0] result;
  logic        ready, stall;

  int checks = 0;
  int errors = 0;

  div_unit dut (
    .clk             (clk),
    .rst             (rst_n),
    .start_i         (start),
    .signed_div_i    (sgn),
    .opdata1_i       (op1),
    .opdata2_i       (op2),
    .annul_i         (annul),
    .result_o        (result),
    .ready_o         (ready),
    .stallreq_for_ex (stall)
  );

  always #5 clk = ~clk;

  // Called at a falling edge. Drives a request, counts stall cycles up to the
  // ready pulse, returns latency (-1 on timeout). Leaves start high if hold.
  task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic hold, input logic scramble,
                         output int lat, output logic [63:0] res, output int stalls);
    sgn = s; op1 = a; op2 = b; start = 1'b1; annul = 1'b0;
    lat = -1; stalls = 0; res = '0;
    #1;
    for (int c = 0; c < 100; c++) begin
      if (c > 0) begin
        @(posedge clk); @(negedge clk);
      end
      if (scramble && c == 1) begin
        op1 = 32'hDEAD_BEEF; op2 = 32'h0000_0003; sgn = ~s;
        #1;
      end
      if (stall) stalls++;
      if (ready) begin
        lat = c; res = result;
        break;
      end
    end
    if (!hold) start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; sgn = 1'b0; annul = 1'b0; op1 = '0; op2 = '0;
    #1;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", ready); end
    checks++; if (result !== 64'h0) begin errors++; $display("FAIL reset_result: got %h want 0", result); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
    @(negedge clk); rst_n = 1'b1; @(negedge clk);
  endtask

  task automatic test_divu_basic();
    int lat, st; logic [63:0] r;
    run_div(1'b0, 32'd100, 32'd7, 1'b0, 1'b0, lat, r, st);
    checks++; if (lat !== 33) begin errors++; $display("FAIL divu_latency: got %0d want 33", lat); end
    checks++; if (st !== 33) begin errors++; $display("FAIL divu_stall_cycles: got %0d want 33", st); end
    checks++; if (r !== 64'h00000002_0000000E) begin errors++; $display("FAIL divu_100_7: got %h want 000000020000000e", r); end
    @(negedge clk);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL ready_one_cycle: got %b want 0", ready); end
    checks++; if (result !== 64'h00000002_0000000E) begin errors++; $display("FAIL result_hold: got %h want 000000020000000e", result); end
    run_div(1'b0, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, lat, r, st);
    checks++; if (r !== 64'h00000001_7FFFFFFC) begin errors++; $display("FAIL divu_big: got %h want 000000017ffffffc", r); end
    @(negedge clk);
  endtask

  task automatic test_signed();
    int lat, st; logic [63:0] r;
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, lat, r, st);
    checks++; if (r !== 64'hFFFFFFFF_FFFFFFFD) begin errors++; $display("FAIL div_m7_2: got %h want fffffffffffffffd", r); end
    checks++; if (lat !== 33) begin errors++; $display("FAIL div_latency: got %0d want 33", lat); end
    @(negedge clk);
    run_div(1'b1, 32'd100, 32'hFFFF_FFF9, 1'b0, 1'b0, lat, r, st);
    checks++; if (r !== 64'h00000002_FFFFFFF2) begin errors++; $display("FAIL div_100_m7: got %h want 00000002fffffff2", r); end
    @(negedge clk);
    run_div(1'b1, 32'hFFFF_FF9C, 32'd7, 1'b0, 1'b0, lat, r, st);
    checks++; if (r !== 64'hFFFFFFFE_FFFFFFF2) begin errors++; $display("FAIL div_m100_7: got %h want fffffffefffffff2", r); end
    @(negedge clk);
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, lat, r, st);
    checks++; if (r !== 64'h00000000_80000000) begin errors++; $display("FAIL div_overflow: got %h want 0000000080000000", r); end
    @(negedge clk);
  endtask

  task automatic test_div_zero();
    int lat, st; logic [63:0] r;
    run_div(1'b0, 32'd5, 32'd0, 1'b0, 1'b0, lat, r, st);
    checks++; if (lat !== 2) begin errors++; $display("FAIL divzero_latency: got %0d want 2", lat); end
    checks++; if (st !== 2) begin errors++; $display("FAIL divzero_stall_cycles: got %0d want 2", st); end
    checks++; if (r !== 64'h0) begin errors++; $display("FAIL divzero_result: got %h want 0", r); end
    @(negedge clk);
  endtask

  task automatic test_operand_hold();
    int lat, st; logic [63:0] r;
    run_div(1'b0, 32'd100, 32'd7, 1'b0, 1'b1, lat, r, st);
    checks++; if (r !== 64'h00000002_0000000E) begin errors++; $display("FAIL operand_latch: got %h want 000000020000000e", r); end
    @(negedge clk);
  endtask

  task automatic test_annul();
    int seen = 0;
    sgn = 1'b0; op1 = 32'd100; op2 = 32'd7; start = 1'b1; annul = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); @(negedge clk);
      if (ready) seen++;
    end
    annul = 1'b1; #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL annul_stall_c10: got %b want 1", stall); end
    @(posedge clk); @(negedge clk);
    start = 1'b0; annul = 1'b0; #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL annul_stall_drop: got %b want 0", stall); end
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); @(negedge clk);
      if (ready) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL annul_no_ready: got %0d pulses want 0", seen); end
  endtask

  task automatic test_async_reset();
    int lat, st; logic [63:0] r;
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, lat, r, st);
    @(negedge clk);
    sgn = 1'b0; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); @(negedge clk);
    end
    #2 rst_n = 1'b0; #1;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rst_mid_ready: got %b want 0", ready); end
    checks++; if (result !== 64'h0) begin errors++; $display("FAIL rst_mid_result: got %h want 0", result); end
    @(negedge clk); start = 1'b0; rst_n = 1'b1; @(negedge clk);
    run_div(1'b0, 32'd9, 32'd3, 1'b0, 1'b0, lat, r, st);
    checks++; if (r !== 64'h00000000_00000003) begin errors++; $display("FAIL rst_after_9_3: got %h want 0000000000000003", r); end
    checks++; if (lat !== 33) begin errors++; $display("FAIL rst_after_latency: got %0d want 33", lat); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat, st; logic [63:0] r;
    run_div(1'b0, 32'd9, 32'd3, 1'b1, 1'b0, lat, r, st);
    checks++; if (r !== 64'h00000000_00000003) begin errors++; $display("FAIL b2b_first: got %h want 0000000000000003", r); end
    op1 = 32'd10; op2 = 32'd4; #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL b2b_gap_stall: got %b want 0", stall); end
    @(posedge clk); @(negedge clk);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL b2b_restall: got %b want 1", stall); end
    run_div(1'b0, 32'd10, 32'd4, 1'b0, 1'b0, lat, r, st);
    checks++; if (lat !== 33) begin errors++; $display("FAIL b2b_latency: got %0d want 33", lat); end
    checks++; if (r !== 64'h00000002_00000002) begin errors++; $display("FAIL b2b_second: got %h want 0000000200000002", r); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_divu_basic();
    test_signed();
    test_div_zero();
    test_operand_hold();
    test_annul();
    test_async_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative 32-bit radix-2 restoring divider for DIV/DIVU in the EX stage.
- Upstream producer of the EX stall request: it raises stallreq_for_ex to the stall controller while a division is in flight.
- The controller freezes IF..EX on that request; this unit then releases the stall with a HI/LO result ready for write-back.

Parameters:
- WIDTH, 32, operand width; the result is 2*WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low.
- start_i  input  1  EX holds a DIV/DIVU; held high by the stalled pipeline until the result is accepted.
- signed_div_i  input  1  1 = DIV (signed), 0 = DIVU.
- opdata1_i  input  WIDTH  dividend (rs).
- opdata2_i  input  WIDTH  divisor (rt).
- annul_i  input  1  flush/exception; abort the division in progress.
- result_o  output  2*WIDTH  {remainder (HI), quotient (LO)}.
- ready_o  output  1  result_o valid this cycle.
- stallreq_for_ex  output  1  stall request to the stall controller.

Behaviour:
- Reset (rst low, any state, immediately):
  - state = IDLE; counter, dividend/divisor registers and result_o cleared to 0.
  - ready_o = 0.
- States: IDLE, DIV_ZERO, ON, END.
- IDLE:
  - If start_i=1 and annul_i=0 and opdata2_i==0, go to DIV_ZERO.
  - If start_i=1 and annul_i=0 and opdata2_i!=0:
    - Latch |opdata1_i| and |opdata2_i|; absolute value only when signed_div_i=1.
    - Latch the sign flags and the mode; clear the counter; go to ON.
  - Otherwise stay in IDLE.
- Operand changes after the start cycle are ignored; only the latched copies are used.
- DIV_ZERO: result = 0, go to END.
- ON, one iteration per cycle:
  - Shift {partial_rem, quotient} left by 1.
  - Trial-subtract the divisor at WIDTH+1 bits; if non-negative, keep the difference and set quotient bit 0.
  - Counter increments; after WIDTH iterations (counter == WIDTH-1 processed), go to END.
- Sign fix-up on the transition into END:
  - Quotient is negated if the operand signs differ (signed mode only).
  - Remainder takes the sign of the dividend.
- END:
  - ready_o = 1 and result_o is valid for exactly one cycle.
  - Next state is IDLE unconditionally.
  - A following DIV restarts from IDLE on the next cycle.
- result_o holds its last value while not ready; consumers sample only when ready_o=1.
- stallreq_for_ex = start_i and not (state==END), combinational.
- Latency, start seen in IDLE at cycle 0:
  - Non-zero divisor: ready_o at cycle WIDTH+1 (33); stallreq high cycles 0..32.
  - Zero divisor: ready_o at cycle 2.
- annul_i:
  - In DIV_ZERO or ON: go to IDLE next cycle; ready_o stays 0; no result is produced.
  - In END: ready_o still pulses but is gated at the stage.
  - annul_i has priority over start_i in IDLE.
- Overflow: signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0 (natural wrap, no trap).
- Absolute values are computed at WIDTH bits; |0x80000000| is treated as unsigned 0x80000000.

Decomposition:
- In the shared defines header:
  - State encodings: DivFree, DivByZero, DivOn, DivEnd.
  - DivResultReady / DivResultNotReady.
  - The existing Stop/NoStop constants for stallreq_for_ex.
- No sub-module is needed. An optional div_step (one combinational shift-subtract step) is the only natural split.

Test Plan:
- DIVU 100/7, start held high → stallreq high 33 cycles; ready_o at cycle 33; result_o = {0x00000002, 0x0000000E}.
- DIV -7/2 (0xFFFFFFF9 / 0x00000002) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
- DIV 0x80000000/0xFFFFFFFF → quotient 0x80000000, remainder 0; DIVU 5/0 → ready_o at cycle 2, result 0.
- Start 100/7, assert annul_i at cycle 10 → IDLE at cycle 11; ready_o never asserts; stallreq drops when start_i falls.
- Assert rst low at cycle 15 of a division → ready_o=0 and result_o=0 immediately without a clock edge; DIVU 9/3 afterwards gives {0, 3}.
- Back-to-back DIVU 9/3 then 10/4 with start_i high continuously → two ready_o pulses; second result {2, 2}; one stall-free cycle between the divisions.
